i2c_slave_regfile: RTL

I2C_SLAVE_REGFILE -- requirements
Module: i2c_slave_regfile

---
 rtl/i2c_slave_regfile.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/i2c_slave_regfile.sv
// i2c_slave_regfile: I2C slave with an 8-bit register file, an auto-incrementing pointer and a local host write/read port
//
// Parameters: SLAVE_ADDR (7-bit device address), NUM_REGS (2..256), PTR_W (pointer width)
// Ports:
//   clk, rst_n              system clock (>= 8x SCL), asynchronous active-low reset
//   scl_i, sda_i            raw I2C pins, asynchronous to clk
//   sda_oe                  1 pulls SDA low, 0 releases it
//   host_addr/we/wdata      local register write port
//   host_rdata              registered read of regs[host_addr], 1-cycle latency
//   wr_strobe, wr_idx       1-cycle pulse and index for each register written over I2C
//   busy                    high from an addressed START until STOP or NACK
// Build option: define I2C_SLAVE_GLITCH_FILTER_EN to add a 3-sample majority filter
// on the synchronized SCL/SDA (2 clk extra latency).
module i2c_slave_regfile #(
    parameter logic [6:0] SLAVE_ADDR = 7'h50,
    parameter int         NUM_REGS   = 16,
    parameter int         PTR_W      = $clog2(NUM_REGS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             scl_i,
    input  logic             sda_i,
    output logic             sda_oe,
    input  logic [PTR_W-1:0] host_addr,
    input  logic             host_we,
    input  logic [7:0]       host_wdata,
    output logic [7:0]       host_rdata,
    output logic             wr_strobe,
    output logic [PTR_W-1:0] wr_idx,
    output logic             busy
);
    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK
    } state_t;

    state_t           state_q;
    logic [1:0]       scl_sync_q, sda_sync_q;
    logic             scl_f, sda_f, scl_prev_q, sda_prev_q;
    logic [7:0]       shift_q, tx_q;
    logic [2:0]       cnt_q;
    logic             ph_q, rw_q;
    logic [PTR_W-1:0] ptr_q;
    logic [7:0]       regs_q [NUM_REGS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync_q <= 2'b11;
            sda_sync_q <= 2'b11;
        end else begin
            scl_sync_q <= {scl_sync_q[0], scl_i};
            sda_sync_q <= {sda_sync_q[0], sda_i};
        end
    end

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
    logic [1:0] scl_hist_q, sda_hist_q;
    logic       scl_flt_q, sda_flt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_hist_q <= 2'b11;
            sda_hist_q <= 2'b11;
            scl_flt_q  <= 1'b1;
            sda_flt_q  <= 1'b1;
        end else begin
            scl_hist_q <= {scl_hist_q[0], scl_sync_q[1]};
            sda_hist_q <= {sda_hist_q[0], sda_sync_q[1]};
            scl_flt_q  <= (scl_sync_q[1] & scl_hist_q[0]) | (scl_sync_q[1] & scl_hist_q[1]) | (scl_hist_q[0] & scl_hist_q[1]);
            sda_flt_q  <= (sda_sync_q[1] & sda_hist_q[0]) | (sda_sync_q[1] & sda_hist_q[1]) | (sda_hist_q[0] & sda_hist_q[1]);
        end
    end

    assign scl_f = scl_flt_q;
    assign sda_f = sda_flt_q;
`else
    assign scl_f = scl_sync_q[1];
    assign sda_f = sda_sync_q[1];
`endif

    logic             scl_rise_d, scl_fall_d, start_d, stop_d;
    logic [7:0]       byte_d;
    logic [PTR_W-1:0] ptr_inc_d, ptr_mod_d;

    assign scl_rise_d = scl_f & ~scl_prev_q;
    assign scl_fall_d = ~scl_f & scl_prev_q;
    assign start_d    = scl_f & scl_prev_q & sda_prev_q & ~sda_f;
    assign stop_d     = scl_f & scl_prev_q & ~sda_prev_q & sda_f;
    assign byte_d     = {shift_q[6:0], sda_f};
    assign ptr_inc_d  = (ptr_q == PTR_W'(NUM_REGS - 1)) ? '0 : ptr_q + PTR_W'(1);
    assign ptr_mod_d  = PTR_W'(32'(byte_d) % NUM_REGS);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
            shift_q    <= '0;
            tx_q       <= '0;
            cnt_q      <= '0;
            ph_q       <= 1'b0;
            rw_q       <= 1'b0;
            ptr_q      <= '0;
            sda_oe     <= 1'b0;
            host_rdata <= '0;
            wr_strobe  <= 1'b0;
            wr_idx     <= '0;
            busy       <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else begin
            scl_prev_q <= scl_f;
            sda_prev_q <= sda_f;
            wr_strobe  <= 1'b0;
            host_rdata <= regs_q[host_addr];
            // The I2C store below is assigned later in this block, so it wins a same-register collision.
            if (host_we) regs_q[host_addr] <= host_wdata;
            if (stop_d) begin
                state_q <= IDLE;
                sda_oe  <= 1'b0;
                busy    <= 1'b0;
                ph_q    <= 1'b0;
            end else if (start_d) begin
                state_q <= ADDR;
                cnt_q   <= '0;
                sda_oe  <= 1'b0;
                ph_q    <= 1'b0;
            end else if (scl_rise_d) begin
                case (state_q)
                    ADDR: begin
                        shift_q <= byte_d;
                        cnt_q   <= cnt_q + 3'd1;
                        if (cnt_q == 3'd7) begin
                            state_q <= (byte_d[7:1] == SLAVE_ADDR) ? ADDR_ACK : IDLE;
                            busy    <= (byte_d[7:1] == SLAVE_ADDR);
                            rw_q    <= byte_d[0];
                        end
                    end
                    PTR: begin
                        shift_q <= byte_d;
                        cnt_q   <= cnt_q + 3'd1;
                        if (cnt_q == 3'd7) begin
                            ptr_q   <= ptr_mod_d;
                            state_q <= PTR_ACK;
                        end
                    end
                    WR_DATA: begin
                        shift_q <= byte_d;
                        cnt_q   <= cnt_q + 3'd1;
                        if (cnt_q == 3'd7) begin
                            regs_q[ptr_q] <= byte_d;
                            wr_strobe     <= 1'b1;
                            wr_idx        <= ptr_q;
                            ptr_q         <= ptr_inc_d;
                            state_q       <= WR_ACK;
                        end
                    end
                    RD_DATA: begin
                        cnt_q <= cnt_q + 3'd1;
                        if (cnt_q == 3'd7) state_q <= RD_ACK;
                    end
                    // ph_q set means SDA is already released and this rise samples the master's ACK/NACK.
                    RD_ACK: if (ph_q && sda_f) begin
                        state_q <= IDLE;
                        busy    <= 1'b0;
                        ph_q    <= 1'b0;
                    end
                    default: ;
                endcase
            end else if (scl_fall_d) begin
                case (state_q)
                    // First fall starts driving the ACK, second fall ends the ACK bit.
                    ADDR_ACK, PTR_ACK, WR_ACK: begin
                        if (!ph_q) begin
                            sda_oe <= 1'b1;
                            ph_q   <= 1'b1;
                        end else begin
                            ph_q  <= 1'b0;
                            cnt_q <= '0;
                            if (state_q == ADDR_ACK && rw_q) begin
                                tx_q    <= regs_q[ptr_q];
                                sda_oe  <= ~regs_q[ptr_q][7];
                                ptr_q   <= ptr_inc_d;
                                state_q <= RD_DATA;
                            end else begin
                                sda_oe  <= 1'b0;
                                state_q <= (state_q == ADDR_ACK) ? PTR : WR_DATA;
                            end
                        end
                    end
                    RD_DATA: begin
                        tx_q   <= {tx_q[6:0], 1'b0};
                        sda_oe <= ~tx_q[6];
                    end
                    RD_ACK: begin
                        if (!ph_q) begin
                            sda_oe <= 1'b0;
                            ph_q   <= 1'b1;
                        end else begin
                            ph_q    <= 1'b0;
                            cnt_q   <= '0;
                            tx_q    <= regs_q[ptr_q];
                            sda_oe  <= ~regs_q[ptr_q][7];
                            ptr_q   <= ptr_inc_d;
                            state_q <= RD_DATA;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule
